// File: rtl/qerv_dbus_pkg.sv
// Shared encodings for the qerv data-bus interface and its lane-select helper.
package qerv_dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // A halfword must sit on an even byte and a word on byte 0; bytes fit anywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lsb[0];
            default: mis = (lsb != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/qerv_dbus_sel.sv
// Byte-lane enables and write-data lane replication from access size and byte offset.
module qerv_dbus_sel
    import qerv_dbus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lsb,
    input  logic [31:0] data,
    output logic [3:0]  sel,
    output logic [31:0] dat
);

    always_comb begin
        sel = 4'b1111;
        dat = data;
        case (size)
            SZ_B: begin
                sel = 4'b0001 << lsb;
                dat = {4{data[7:0]}};
            end
            SZ_H: begin
                // An odd offset is truncated to the enclosing halfword.
                sel = 4'b0011 << {lsb[1], 1'b0};
                dat = {2{data[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qerv_dbus_if.sv
// Serial data-bus interface: one classic bus cycle per load/store, loads returned W bits per cycle.
// Optional QERV_DBUS_MISALIGN_TRAP_EN rejects misaligned requests and pulses o_misalign.
module qerv_dbus_if
    import qerv_dbus_pkg::*;
#(
    parameter  int W = 1,
    localparam int B = W - 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_st_en,
    input  logic [B:0]  i_rs2,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_lsb,
    input  logic [31:0] i_adr,
    input  logic        i_ld_en,
    output logic [B:0]  o_rd,
    output logic [31:0] o_dbus_adr,
    output logic [31:0] o_dbus_dat,
    output logic [3:0]  o_dbus_sel,
    output logic        o_dbus_we,
    output logic        o_dbus_cyc,
    input  logic [31:0] i_dbus_rdt,
    input  logic        i_dbus_ack,
    output logic        o_ack,
    output logic        o_busy
`ifdef QERV_DBUS_MISALIGN_TRAP_EN
    ,
    output logic        o_misalign
`endif
);

    state_t      state_reg, state_next;
    logic [31:0] data_reg;
    logic [31:0] adr_reg;
    logic [31:0] dat_reg;
    logic [3:0]  sel_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic [1:0]  lsb_reg;
    logic        signed_reg;
    logic        sign_reg;
    logic [4:0]  count_reg;

    logic [3:0]  sel_next;
    logic [31:0] dat_next;
    logic        misalign;
    logic        accept;
    logic        bus_done;
    logic        ld_shift;
    logic        hold_last;
    logic [31:0] rdt_shifted;
    logic [B:0]  rd_masked;

    qerv_dbus_sel u_sel (
        .size (i_size),
        .lsb  (i_lsb),
        .data (data_reg),
        .sel  (sel_next),
        .dat  (dat_next)
    );

`ifdef QERV_DBUS_MISALIGN_TRAP_EN
    assign misalign = (state_reg == IDLE) && i_req && is_misaligned(i_size, i_lsb);
`else
    assign misalign = 1'b0;
`endif

    assign accept      = (state_reg == IDLE) && i_req && !misalign;
    assign bus_done    = (state_reg == BUS) && i_dbus_ack;
    assign ld_shift    = (state_reg == HOLD) && i_ld_en;
    assign hold_last   = (count_reg == 5'(32 - W));
    assign rdt_shifted = i_dbus_rdt >> {lsb_reg, 3'b000};

    // Bits beyond the loaded width are replaced by the captured sign (or zero).
    for (genvar gi = 0; gi < W; gi++) begin : g_rd
        logic [5:0] pos;
        assign pos = {1'b0, count_reg} + 6'(gi);
        assign rd_masked[gi] = ((size_reg == SZ_B && pos >= 6'd8) ||
                                (size_reg == SZ_H && pos >= 6'd16)) ? sign_reg : data_reg[gi];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BUS;
            BUS:     if (i_dbus_ack) state_next = we_reg ? IDLE : HOLD;
            HOLD:    if (i_ld_en && hold_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_dbus_cyc = (state_reg == BUS);
        o_ack      = bus_done;
        o_busy     = (state_reg != IDLE);
        o_rd       = '0;
        if (ld_shift) o_rd = rd_masked;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg   <= '0;
            adr_reg    <= '0;
            dat_reg    <= '0;
            sel_reg    <= '0;
            we_reg     <= 1'b0;
            size_reg   <= SZ_W;
            lsb_reg    <= '0;
            signed_reg <= 1'b0;
            sign_reg   <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (accept) begin
                adr_reg    <= i_adr;
                we_reg     <= i_we;
                size_reg   <= i_size;
                lsb_reg    <= i_lsb;
                signed_reg <= i_signed;
                sel_reg    <= sel_next;
                dat_reg    <= dat_next;
            end
            if (bus_done && !we_reg) begin
                data_reg  <= rdt_shifted;
                count_reg <= '0;
                sign_reg  <= signed_reg & ((size_reg == SZ_H) ? rdt_shifted[15] : rdt_shifted[7]);
            end else if (ld_shift) begin
                data_reg  <= data_reg >> W;
                count_reg <= count_reg + 5'(W);
            end else if (i_st_en && state_reg != BUS) begin
                data_reg <= {i_rs2, data_reg[31:W]};
            end
        end
    end

`ifdef QERV_DBUS_MISALIGN_TRAP_EN
    logic misalign_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign;
        end
    end
    assign o_misalign = misalign_reg;
`endif

    assign o_dbus_adr = adr_reg;
    assign o_dbus_dat = dat_reg;
    assign o_dbus_sel = sel_reg;
    assign o_dbus_we  = we_reg;

endmodule

// File: tb/tb_qerv_dbus_if.sv
// Directed table plus randomized transactions for qerv_dbus_if, checked against a lane/width model.
module tb_qerv_dbus_if;

    localparam int W = 1;
    localparam int B = W - 1;
    localparam int NSHIFT = 32 / W;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_st_en;
    logic [B:0]  i_rs2;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_signed;
    logic [1:0]  i_lsb;
    logic [31:0] i_adr;
    logic        i_ld_en;
    logic [B:0]  o_rd;
    logic [31:0] o_dbus_adr;
    logic [31:0] o_dbus_dat;
    logic [3:0]  o_dbus_sel;
    logic        o_dbus_we;
    logic        o_dbus_cyc;
    logic [31:0] i_dbus_rdt;
    logic        i_dbus_ack;
    logic        o_ack;
    logic        o_busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 i_clk = ~i_clk;

    qerv_dbus_if #(.W(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_st_en    (i_st_en),
        .i_rs2      (i_rs2),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_size     (i_size),
        .i_signed   (i_signed),
        .i_lsb      (i_lsb),
        .i_adr      (i_adr),
        .i_ld_en    (i_ld_en),
        .o_rd       (o_rd),
        .o_dbus_adr (o_dbus_adr),
        .o_dbus_dat (o_dbus_dat),
        .o_dbus_sel (o_dbus_sel),
        .o_dbus_we  (o_dbus_we),
        .o_dbus_cyc (o_dbus_cyc),
        .i_dbus_rdt (i_dbus_rdt),
        .i_dbus_ack (i_dbus_ack),
        .o_ack      (o_ack),
        .o_busy     (o_busy)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lsb;
        logic [31:0] adr;
        logic [31:0] st_word;
        logic [31:0] rdt;
        int          ack_delay;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: an access covers n bytes starting at the offset rounded down to a multiple of n.
    function automatic int nbytes_of(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [1:0] lsb);
        int n, start;
        logic [3:0] s;
        n = nbytes_of(size);
        start = (int'(lsb) / n) * n;
        for (int l = 0; l < 4; l++) s[l] = (l >= start) && (l < start + n);
        return s;
    endfunction

    function automatic logic [31:0] m_dat(input logic [1:0] size, input logic [31:0] st);
        int n;
        logic [31:0] d;
        n = nbytes_of(size);
        for (int l = 0; l < 4; l++) d[8*l +: 8] = st[8*(l % n) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] size, input logic [1:0] lsb,
                                         input logic sgn, input logic [31:0] rdt);
        longint x;
        int nb;
        nb = 8 * nbytes_of(size);
        x = longint'(rdt) >> (8 * int'(lsb));
        x = x & ((64'sd1 <<< nb) - 1);
        if (sgn && nb < 32 && x[nb-1]) x = x - (64'sd1 <<< nb);
        return x[31:0];
    endfunction

    task automatic shift_store(input logic [31:0] word);
        for (int i = 0; i < NSHIFT; i++) begin
            i_st_en = 1'b1;
            i_rs2   = word[i*W +: W];
            @(posedge i_clk); #1;
        end
        i_st_en = 1'b0;
        i_rs2   = '0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] rd;
        int ncyc, nack;
        rd = '0; ncyc = 0; nack = 0;
        shift_store(v.st_word);
        i_req = 1'b1; i_we = v.we; i_size = v.size; i_signed = v.sgn; i_lsb = v.lsb; i_adr = v.adr;
        @(posedge i_clk); #1;
        i_req = 1'b0; i_we = ~v.we; i_size = 2'($urandom); i_signed = ~v.sgn;
        i_lsb = 2'($urandom); i_adr = $urandom;
        for (int k = 0; k <= v.ack_delay; k++) begin
            i_dbus_ack = (k == v.ack_delay);
            i_dbus_rdt = (k == v.ack_delay) ? v.rdt : $urandom;
            @(negedge i_clk);
            if (o_dbus_cyc) ncyc++;
            if (o_ack) nack++;
            check({tag, ".sel"}, 32'(o_dbus_sel), 32'(v.exp_sel));
            check({tag, ".dat"}, o_dbus_dat, v.exp_dat);
            check({tag, ".adr"}, o_dbus_adr, v.adr);
            check({tag, ".we"},  32'(o_dbus_we), 32'(v.we));
            @(posedge i_clk); #1;
            i_dbus_ack = 1'b0;
        end
        @(negedge i_clk);
        check({tag, ".cyc_cycles"}, 32'(ncyc), 32'(v.ack_delay + 1));
        check({tag, ".ack_pulses"}, 32'(nack), 32'd1);
        check({tag, ".cyc_after"},  32'(o_dbus_cyc), 32'd0);
        check({tag, ".busy_after"}, 32'(o_busy), 32'(!v.we));
        if (!v.we) begin
            check({tag, ".rd_idle"}, 32'(o_rd), 32'd0);
            @(posedge i_clk); #1;
            for (int i = 0; i < NSHIFT; i++) begin
                i_ld_en = 1'b1;
                @(negedge i_clk);
                rd[i*W +: W] = o_rd;
                @(posedge i_clk); #1;
            end
            i_ld_en = 1'b0;
            @(negedge i_clk);
            check({tag, ".rd"}, rd, v.exp_rd);
            check({tag, ".hold_exit"}, 32'(o_busy), 32'd0);
        end
        @(posedge i_clk); #1;
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 2'b10, 1'b0, 2'd0, 32'h100, 32'hDEADBEEF, 32'h0,        2, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 2'b00, 1'b0, 2'd2, 32'h204, 32'h000000A5, 32'h0,        1, 4'b0100, 32'hA5A5A5A5, 32'h0};
        tbl[2] = '{1'b0, 2'b00, 1'b1, 2'd2, 32'h300, 32'h0,        32'h00800000, 1, 4'b0100, 32'h0,        32'hFFFFFF80};
        tbl[3] = '{1'b0, 2'b00, 1'b0, 2'd2, 32'h300, 32'h0,        32'h00800000, 0, 4'b0100, 32'h0,        32'h00000080};
        tbl[4] = '{1'b0, 2'b01, 1'b0, 2'd2, 32'h400, 32'h0,        32'h80011234, 3, 4'b1100, 32'h0,        32'h00008001};
        tbl[5] = '{1'b0, 2'b01, 1'b1, 2'd2, 32'h400, 32'h0,        32'h80011234, 0, 4'b1100, 32'h0,        32'hFFFF8001};
        tbl[6] = '{1'b1, 2'b01, 1'b0, 2'd2, 32'h500, 32'h12345678, 32'h0,        1, 4'b1100, 32'h56785678, 32'h0};
        tbl[7] = '{1'b0, 2'b10, 1'b1, 2'd0, 32'h600, 32'h0,        32'hCAFEF00D, 2, 4'b1111, 32'h0,        32'hCAFEF00D};
        tbl[8] = '{1'b1, 2'b11, 1'b0, 2'd0, 32'h700, 32'h0BADF00D, 32'h0,        0, 4'b1111, 32'h0BADF00D, 32'h0};

        i_rst_n = 1'b0; i_st_en = 1'b0; i_rs2 = '0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00;
        i_signed = 1'b0; i_lsb = 2'd0; i_adr = '0; i_ld_en = 1'b0; i_dbus_rdt = '0; i_dbus_ack = 1'b0;
        #3;
        check("reset.cyc",  32'(o_dbus_cyc), 32'd0);
        check("reset.busy", 32'(o_busy), 32'd0);
        check("reset.ack",  32'(o_ack), 32'd0);
        check("reset.sel",  32'(o_dbus_sel), 32'd0);
        check("reset.adr",  o_dbus_adr, 32'd0);
        check("reset.dat",  o_dbus_dat, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
            $display("tbl%0d: we=%0d size=%0d lsb=%0d done", i, tbl[i].we, tbl[i].size, tbl[i].lsb);
        end

        // Reset asserted while the bus cycle is waiting for ack.
        shift_store(32'h11112222);
        i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_lsb = 2'd0; i_adr = 32'h800;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        @(negedge i_clk);
        check("rst_mid.cyc_before", 32'(o_dbus_cyc), 32'd1);
        #1 i_rst_n = 1'b0;
        #1;
        check("rst_mid.cyc",  32'(o_dbus_cyc), 32'd0);
        check("rst_mid.busy", 32'(o_busy), 32'd0);
        check("rst_mid.ack",  32'(o_ack), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_vec("rst_mid.after", tbl[0]);
        $display("rst_mid: reset during BUS, then word store done");

        for (int i = 0; i < 40; i++) begin
            rv.we        = 1'($urandom);
            rv.size      = 2'($urandom);
            rv.sgn       = 1'($urandom);
            rv.lsb       = 2'($urandom);
            rv.adr       = $urandom & 32'hFFFF_FFFC;
            rv.st_word   = $urandom;
            rv.rdt       = $urandom;
            rv.ack_delay = int'($urandom_range(0, 3));
            rv.exp_sel   = m_sel(rv.size, rv.lsb);
            rv.exp_dat   = m_dat(rv.size, rv.st_word);
            rv.exp_rd    = m_rd(rv.size, rv.lsb, rv.sgn, rv.rdt);
            run_vec($sformatf("rnd%0d", i), rv);
            $display("rnd%0d: we=%0d size=%0d sgn=%0d lsb=%0d delay=%0d", i, rv.we, rv.size, rv.sgn,
                     rv.lsb, rv.ack_delay);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/qerv_dbus_if.md
Name: qerv_dbus_if

Overview:
- Data-bus interface stage directly downstream of the buffer register.
- Consumes the word-aligned address and the two address LSBs produced by the buffer register, plus serial store data from rs2.
- Runs one Wishbone-style classic cycle per load/store request.
- Returns load data to the register file serially, W bits per cycle, right-aligned and sign- or zero-extended.

Parameters:
W, 1, serial datapath width in bits per cycle; legal values 1 and 4
B, W-1, MSB index of the serial data ports

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_st_en  in  1  shift i_rs2 into the data register this cycle (store-data collection)
i_rs2  in  W  serial store data, LSB first
i_req  in  1  single-cycle start-of-transaction strobe; honoured only in IDLE
i_we  in  1  1 = store, 0 = load; sampled with i_req
i_size  in  2  00 byte, 01 half, 10 word; 11 treated as word; sampled with i_req
i_signed  in  1  sign-extend loads; sampled with i_req
i_lsb  in  2  byte offset from the buffer register; sampled with i_req
i_adr  in  32  word-aligned address from the buffer register; sampled with i_req
i_ld_en  in  1  shift out W load bits this cycle
o_rd  out  W  serial load data, LSB first
o_dbus_adr  out  32  bus address
o_dbus_dat  out  32  bus write data
o_dbus_sel  out  4  byte-lane enables
o_dbus_we  out  1  bus write enable
o_dbus_cyc  out  1  bus cycle request
i_dbus_rdt  in  32  bus read data
i_dbus_ack  in  1  bus acknowledge
o_ack  out  1  one-cycle pulse when the transaction completes
o_busy  out  1  high in BUS and HOLD states

Behaviour:
Reset (asynchronous, i_rst_n low):
- state = IDLE; data, adr, sel, we, count cleared.
- o_dbus_cyc, o_ack and o_busy are 0 immediately.
- Reset asserted mid-BUS drops cyc without waiting for ack.

Store-data collection, any state except BUS:
- On i_st_en: data <= {i_rs2, data[31:W]}.
- 32/W enables load the full rs2 word.

States:
- IDLE
  - Accepts i_req; latches adr, we, size, signed, lsb.
  - Sel: byte = 0001<<lsb; half = 0011<<{lsb[1],0}; word = 1111.
  - Write data: byte -> {4{data[7:0]}}; half -> {2{data[15:0]}}; word -> data.
  - Enters BUS the next cycle with cyc = 1.
- BUS
  - cyc held until the first cycle i_dbus_ack = 1.
  - On ack: cyc <= 0, o_ack = 1 for one cycle.
  - Load: data <= i_dbus_rdt >> (8*lsb), count <= 0, go to HOLD.
  - Store: go to IDLE.
  - i_req is ignored in BUS.
- HOLD (load only)
  - Each i_ld_en: o_rd = data[B:0] after masking; data shifts right by W; count += W (5-bit).
  - Masking: bits at position >= 8 (byte) or >= 16 (half) are replaced by the sign bit (if signed) or 0.
  - Sign bit is captured at ack from bit 7 or bit 15 of the shifted word.
  - Count wrap to 0 (32 bits out) returns to IDLE.
  - i_req is ignored in HOLD.

Output timing:
- o_rd = 0 whenever i_ld_en = 0.
- o_dbus_sel, o_dbus_we and o_dbus_dat are registered and stable throughout BUS.
- Ack in the first BUS cycle is legal; minimum transaction is 2 cycles from i_req.

Optional Feature:
Macro: QERV_DBUS_MISALIGN_TRAP_EN
- Defined:
  - i_req with half and lsb[0] = 1, or word and lsb != 0, produces no bus cycle.
  - o_misalign (extra 1-bit output) pulses for one cycle, state stays IDLE, o_ack is not asserted.
- Undefined:
  - No o_misalign port.
  - Misaligned requests issue the bus cycle with the sel rules above; the offset is truncated by sel generation.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 0, BUS = 1, HOLD = 2;
  - size constants SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10.
- One natural sub-module: qerv_dbus_sel, combinational sel and write-data replication from size/lsb. It is reused by the instruction-fetch side.

Test Plan:
- Word store: shift 0xDEADBEEF via 32/W i_st_en, i_req we=1 size=10 lsb=0 adr=0x100, ack after 3 cycles -> cyc high 3 cycles, sel=1111, dat=0xDEADBEEF, one o_ack, back to IDLE.
- Byte store: rs2=0x000000A5, size=00, lsb=2 -> sel=0100, dat=0xA5A5A5A5.
- Signed byte load: rdt=0x0080_0000, lsb=2, signed=1 -> serialized o_rd reassembles to 0xFFFFFF80; unsigned gives 0x00000080.
- Half load: rdt=0x8001_1234, lsb=2, signed=0 -> 0x00008001; HOLD exits after exactly 32/W i_ld_en.
- Reset mid-BUS: assert i_rst_n=0 with cyc=1, no ack -> cyc=0 in the same cycle, o_busy=0, second i_req after release runs normally.
- With QERV_DBUS_MISALIGN_TRAP_EN: word load lsb=1 -> o_misalign pulse, cyc never rises, o_ack=0.
